// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for the ID-to-EX pipeline boundary with flush and freeze.
// Optional performance counters (stall_cnt, bubble_cnt) are built when PIPE_SKID_PERF_CNT_EN is defined.
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 150,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              freeze
`ifdef PIPE_SKID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, consume;

  assign in_ready  = (state_q != ST_FULL) && !freeze;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready && !freeze;

  // State and storage registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state: freeze holds, flush empties, otherwise move payloads in order.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (freeze) begin
      state_d = state_q;
    end else if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_PERF_CNT_EN
  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && out_ready && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_pipe_skid_reg;
  localparam int unsigned DW   = 150;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, flush, freeze;
  logic [DW-1:0] in_data, out_data;
`ifdef PIPE_SKID_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

  pipe_skid_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .freeze(freeze)
`ifdef PIPE_SKID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: FIFO of at most two payloads plus saturating counters.
  logic [DW-1:0] q[$];
  int m_stall  = 0;
  int m_bubble = 0;

  function automatic logic exp_ready();
    return (q.size() < 2) && !freeze;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic drive(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       input logic fl, input logic fz);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    freeze    = fz;
  endtask

  // Advance the model by one clock edge, then the DUT; returns at posedge+1.
  task automatic step();
    logic rdy, vld;
    rdy = exp_ready();
    vld = (q.size() != 0);
    if (in_valid && !rdy && m_stall < CMAX) m_stall++;
    if (!vld && out_ready && m_bubble < CMAX) m_bubble++;
    if (!freeze) begin
      if (flush) q.delete();
      else begin
        if (vld && out_ready) void'(q.pop_front());
        if (in_valid && rdy) q.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    q.delete();
    m_stall  = 0;
    m_bubble = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #12;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else n_pass++;
    n_total++;
    if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else n_pass++;
`ifdef PIPE_SKID_PERF_CNT_EN
    n_total++;
    if (stall_cnt !== '0 || bubble_cnt !== '0)
      $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, bubble_cnt);
    else n_pass++;
`endif
    reset_dut();
  endtask

  task automatic test_latency();
    reset_dut();
    drive(1'b1, DW'(8'h5A), 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    n_total++;
    if (out_valid !== 1'b1 || out_data !== DW'(8'h5A))
      $display("FAIL latency_out got v=%b d=%h want v=1 d=5a", out_valid, out_data);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL latency_in_ready got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    reset_dut();
    drive(1'b1, DW'(8'h11), 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, DW'(8'h22), 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    n_total++;
    if (in_ready !== 1'b0 || out_data !== DW'(8'h11) || out_valid !== 1'b1)
      $display("FAIL bp_full got r=%b v=%b d=%h want r=0 v=1 d=11", in_ready, out_valid, out_data);
    else n_pass++;
    out_ready = 1'b1;
    step();
    #3;
    n_total++;
    if (out_valid !== 1'b1 || out_data !== DW'(8'h22))
      $display("FAIL bp_second got v=%b d=%h want v=1 d=22", out_valid, out_data);
    else n_pass++;
    step();
    #3;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0)
      $display("FAIL bp_drained got v=%b d=%h want v=0 d=0", out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_flush();
    reset_dut();
    drive(1'b1, DW'(8'h11), 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, DW'(8'h22), 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, DW'(8'h33), 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #3;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1)
      $display("FAIL flush_empty got v=%b d=%h r=%b want v=0 d=0 r=1", out_valid, out_data, in_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      #3;
      n_total++;
      if (out_valid !== 1'b0 || out_data !== '0)
        $display("FAIL flush_no_ghost got v=%b d=%h want v=0 d=0", out_valid, out_data);
      else n_pass++;
    end
  endtask

  task automatic test_freeze();
    reset_dut();
    drive(1'b1, DW'(8'h44), 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, DW'(8'h55), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #3;
      n_total++;
      if (out_data !== DW'(8'h44) || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL freeze_hold got d=%h v=%b r=%b want d=44 v=1 r=0", out_data, out_valid, in_ready);
      else n_pass++;
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #3;
    n_total++;
    if (out_data !== DW'(8'h44) || out_valid !== 1'b1)
      $display("FAIL freeze_release got d=%h v=%b want d=44 v=1", out_data, out_valid);
    else n_pass++;
    step();
    #3;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL freeze_consumed got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    reset_dut();
    drive(1'b1, DW'(8'h11), 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, DW'(8'h22), 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0)
      $display("FAIL async_reset got v=%b d=%h want v=0 d=0", out_valid, out_data);
    else n_pass++;
    q.delete();
    m_stall  = 0;
    m_bubble = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef PIPE_SKID_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset_dut();
    for (int i = 0; i < 22; i++) begin
      drive(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
      step();
    end
    #3;
    n_total++;
    if (int'(stall_cnt) !== 15) $display("FAIL stall_saturate got %0d want 15", stall_cnt);
    else n_pass++;
    drive(1'b1, rnd_data(), 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    n_total++;
    if (int'(stall_cnt) !== 15) $display("FAIL stall_after_flush got %0d want 15", stall_cnt);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (stall_cnt !== '0 || bubble_cnt !== '0)
      $display("FAIL cnt_rst got %0d/%0d want 0/0", stall_cnt, bubble_cnt);
    else n_pass++;
    q.delete();
    m_stall  = 0;
    m_bubble = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
`endif

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), rnd_data(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      #3;
      n_total++;
      if (in_ready !== exp_ready() || out_valid !== (q.size() != 0) || out_data !== exp_data())
        $display("FAIL random_cycle%0d got r=%b v=%b d=%h want r=%b v=%b d=%h", i,
                 in_ready, out_valid, out_data, exp_ready(), (q.size() != 0), exp_data());
      else n_pass++;
`ifdef PIPE_SKID_PERF_CNT_EN
      n_total++;
      if (int'(stall_cnt) !== m_stall || int'(bubble_cnt) !== m_bubble)
        $display("FAIL random_cnt%0d got %0d/%0d want %0d/%0d", i,
                 stall_cnt, bubble_cnt, m_stall, m_bubble);
      else n_pass++;
`endif
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_latency();
    test_backpressure();
    test_flush();
    test_freeze();
    test_async_reset();
`ifdef PIPE_SKID_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 150, payload width in bits (full ID-to-EX bundle: PC, Rn/Rm values, immediates, control bits).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream holds a valid payload.
REQ-006 in_data  input  DATA_W  upstream payload.
REQ-007 in_ready  output  1  block accepts a payload this cycle.
REQ-008 out_valid  output  1  out_data holds a valid payload.
REQ-009 out_data  output  DATA_W  registered payload to the downstream stage.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 flush  input  1  discard all held and incoming payloads (branch taken).
REQ-012 freeze  input  1  hold all state (hazard stall).
REQ-013 stall_cnt  output  CNT_W  cycles with in_valid=1 and in_ready=0 (present only under the macro in REQ-030).
REQ-014 bubble_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1 (present only under the macro in REQ-030).

Function
REQ-015 Storage SHALL be two entries: main register (drives out_data) and skid register; state is EMPTY (neither valid), ONE (main valid), or FULL (main and skid valid).
REQ-016 in_ready SHALL equal (state != FULL) and not freeze; out_valid SHALL equal (state != EMPTY); both are derived from registered state only, except the freeze term.
REQ-017 Accept = in_valid and in_ready; consume = out_valid and out_ready and not freeze.
REQ-018 EMPTY: accept -> ONE, main <= in_data; otherwise stay.
REQ-019 ONE: accept and consume -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; consume only -> EMPTY, main <= 0; neither -> stay.
REQ-020 FULL: consume -> ONE, main <= skid, skid <= 0; otherwise stay (no accept possible).
REQ-021 Latency SHALL be one cycle: payload accepted at edge N is on out_data with out_valid=1 after edge N when state was EMPTY or consumed in the same cycle.
REQ-022 Payload order SHALL be preserved; no payload is duplicated or dropped except by flush.
REQ-023 out_data SHALL be all-zero whenever state is EMPTY (bubble is a NOP with all control bits clear).
REQ-024 Priority SHALL be rst > freeze > flush > normal operation.
REQ-025 freeze=1: state, main, skid held unchanged; in_ready=0; a flush asserted in the same cycle is ignored.
REQ-026 flush=1 with freeze=0: next state EMPTY, main and skid zeroed, any payload presented that cycle is discarded, counters unaffected.

Reset
REQ-027 On rst: state EMPTY, main=0, skid=0, out_valid=0, out_data=0, in_ready=1 (freeze low), stall_cnt=0, bubble_cnt=0.
REQ-028 Reset asserted mid-operation SHALL discard held payloads immediately, without waiting for a clock edge.
REQ-029 After rst deassertion the first accept SHALL occur at the first rising edge with in_valid=1.

Configuration
REQ-030 Macro PIPE_SKID_PERF_CNT_EN: when defined, stall_cnt and bubble_cnt exist, each increments by 1 per qualifying cycle (REQ-013/014), saturates at 2^CNT_W-1, and is cleared only by rst; when undefined, both ports and all counter logic are absent and the remaining behaviour is identical.

Verification
REQ-031 rst pulse, then in_valid=1, in_data=0x5A, out_ready=1 -> after one edge out_valid=1, out_data=0x5A, in_ready=1.
REQ-032 out_ready=0, push 0x11 then 0x22 -> state FULL, in_ready=0, out_data=0x11; raise out_ready -> 0x11 then 0x22 consumed in order, then out_valid=0, out_data=0.
REQ-033 State FULL (0x11, 0x22), flush=1 with in_valid=1, in_data=0x33 for one cycle -> out_valid=0, out_data=0, in_ready=1; 0x33 never appears.
REQ-034 State ONE (0x44), freeze=1 and flush=1 for 3 cycles, out_ready=1 -> out_data stays 0x44, out_valid=1, in_ready=0; after freeze drops, 0x44 consumed normally.
REQ-035 Macro defined, CNT_W=4: in_valid=1 with state FULL and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; flush leaves it 15; rst clears it to 0.
REQ-036 rst asserted asynchronously between edges while FULL -> out_valid and out_data go to 0 before the next rising edge.
